// File: rtl/wb_gpio_irq_bridge.sv
`default_nettype none
// ============================================================================
// Module : wb_gpio_irq_bridge
// Wishbone classic GPIO slave with per-pin edge interrupts; optional input
// debounce enabled by defining GPIO_DEBOUNCE_EN.
// Rev    : 1.0
// ============================================================================
module wb_gpio_irq_bridge #(
    parameter int          NUM_IO     = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          WIN_BITS   = 8,
    parameter int          DEB_CYCLES = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic              irq_o
);

    localparam logic [WIN_BITS-3:0] c_w_dout   = (WIN_BITS-2)'(0);
    localparam logic [WIN_BITS-3:0] c_w_oe     = (WIN_BITS-2)'(1);
    localparam logic [WIN_BITS-3:0] c_w_din    = (WIN_BITS-2)'(2);
    localparam logic [WIN_BITS-3:0] c_w_irq_en = (WIN_BITS-2)'(3);
    localparam logic [WIN_BITS-3:0] c_w_edge   = (WIN_BITS-2)'(4);
    localparam logic [WIN_BITS-3:0] c_w_status = (WIN_BITS-2)'(5);

    logic [NUM_IO-1:0] r_dout, r_oe, r_irq_en, r_edge, r_status;
    logic [NUM_IO-1:0] r_s1, r_s2, r_f, r_f_prev, r_evt;
    logic              r_ack, r_irq;
    logic [31:0]       r_dat;

    logic              w_hit, w_req, w_wr;
    logic [WIN_BITS-3:0] w_word;
    logic [31:0]       w_bmask, w_rdata;
    logic [NUM_IO-1:0] w_w1c, w_evt;
    logic              w_unused_ok;

    assign w_hit   = (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign w_req   = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
    assign w_wr    = w_req & wbs_we_i;
    assign w_word  = wbs_adr_i[WIN_BITS-1:2];
    assign w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_unused_ok = ^{wbs_adr_i[1:0], 16'(DEB_CYCLES)};

    // Byte-lane merge of write data into a register; bits above NUM_IO drop.
    function automatic logic [NUM_IO-1:0] merge(input logic [NUM_IO-1:0] old);
        logic [31:0] m;
        m = (32'(old) & ~w_bmask) | (wbs_dat_i & w_bmask);
        return m[NUM_IO-1:0];
    endfunction

    assign w_w1c = (w_wr && w_word == c_w_status) ? merge('0) : '0;
    assign w_evt = (r_edge & r_f & ~r_f_prev) | (~r_edge & ~r_f & r_f_prev);

    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_w_dout:   w_rdata = 32'(r_dout);
            c_w_oe:     w_rdata = 32'(r_oe);
            c_w_din:    w_rdata = 32'(r_f);
            c_w_irq_en: w_rdata = 32'(r_irq_en);
            c_w_edge:   w_rdata = 32'(r_edge);
            c_w_status: w_rdata = 32'(r_status);
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_dout   <= '0;
            r_oe     <= '0;
            r_irq_en <= '0;
            r_edge   <= '0;
            r_status <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_f_prev <= '0;
            r_evt    <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs_we_i) ? w_rdata : 32'd0;
            if (w_wr) begin
                case (w_word)
                    c_w_dout:   r_dout   <= merge(r_dout);
                    c_w_oe:     r_oe     <= merge(r_oe);
                    c_w_irq_en: r_irq_en <= merge(r_irq_en);
                    c_w_edge:   r_edge   <= merge(r_edge);
                    default:    ;
                endcase
            end
            r_s1     <= io_in;
            r_s2     <= r_s1;
            r_f_prev <= r_f;
            r_evt    <= w_evt;
            // A new event on a bit wins over a W1C landing on the same edge.
            r_status <= (r_status & ~w_w1c) | r_evt;
            r_irq    <= |(r_status & r_irq_en);
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [15:0] c_deb_term = 16'(DEB_CYCLES);
    logic [15:0] r_cnt [NUM_IO];

    // Terminal count of DEB_CYCLES delays f by exactly DEB_CYCLES extra cycles.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_f <= '0;
            for (int i = 0; i < NUM_IO; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IO; i++) begin
                if (r_s2[i] == r_f[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_deb_term) begin
                    r_f[i]   <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_f <= '0;
        else          r_f <= r_s2;
    end
`endif

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_dout;
    assign io_oeb    = ~r_oe;
    assign irq_o     = r_irq;

endmodule
`default_nettype wire
